// File: rtl/dds_iq_seq.sv
// dds_iq_seq: burst/continuous I/Q sine sequencer driving a two-port registered
// quarter-sine LUT.
//
// Owns the phase accumulator and frequency control word. Each phase is folded
// into a quarter-wave LUT address (sine on port 1, cosine on port 2). The
// quadrant sign travels alongside the LUT read and is applied when the samples
// are registered.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, stop           run control pulses
//   burst_len             samples per burst (0 = continuous), captured on start
//   phase_init            starting phase, captured on start
//   fcw, fcw_we           frequency control word and its load strobe
//   lut_addr1, lut_addr2  sine / cosine LUT addresses (combinational from phase)
//   lut_data1, lut_data2  LUT read data, one cycle after address, non-negative
//   sin_out, cos_out      signed output samples
//   out_valid             samples valid this cycle
//   busy                  high in RUN or DRAIN
//   done                  one-cycle pulse on return to IDLE
module dds_iq_seq #(
    parameter int unsigned PW    = 32,
    parameter int unsigned ABITS = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned LW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [LW-1:0]    burst_len,
    input  logic [PW-1:0]    phase_init,
    input  logic [PW-1:0]    fcw,
    input  logic             fcw_we,
    output logic [ABITS-1:0] lut_addr1,
    output logic [ABITS-1:0] lut_addr2,
    input  logic [DW-1:0]    lut_data1,
    input  logic [DW-1:0]    lut_data2,
    output logic [DW-1:0]    sin_out,
    output logic [DW-1:0]    cos_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [PW-1:0]   fcw_reg;
    logic [LW-1:0]   count;
    logic            continuous;
    logic            drain_cnt;

    logic [1:0]       quad_sin;
    logic [1:0]       quad_cos;
    logic [ABITS-1:0] idx;
    logic             issue;

    // Sign bits delayed to line up with the LUT read data.
    logic issue_d;
    logic neg_sin_d;
    logic neg_cos_d;

    logic unused_phase_lsbs;

    // Phase folding: cosine is sine one quadrant ahead; odd quadrants read the
    // table mirrored, upper half-circle is negated.
    assign quad_sin  = phase[PW-1 -: 2];
    assign quad_cos  = quad_sin + 2'd1;
    assign idx       = phase[PW-3 -: ABITS];
    assign lut_addr1 = quad_sin[0] ? ~idx : idx;
    assign lut_addr2 = quad_cos[0] ? ~idx : idx;

    assign issue = (state == StRun) && !stop;

    assign unused_phase_lsbs = ^phase[PW-3-ABITS:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_reg <= '0;
        end else if (fcw_we) begin
            fcw_reg <= fcw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            phase      <= '0;
            count      <= '0;
            continuous <= 1'b0;
            drain_cnt  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StRun;
                        phase      <= phase_init;
                        count      <= burst_len;
                        continuous <= (burst_len == '0);
                        busy       <= 1'b1;
                    end
                end
                StRun: begin
                    if (stop) begin
                        // Stop cycle issues nothing, even if it was the last sample.
                        state     <= StDrain;
                        drain_cnt <= 1'b0;
                    end else begin
                        phase <= phase + fcw_reg;
                        if (!continuous) begin
                            count <= count - LW'(1);
                            if (count == LW'(1)) begin
                                state     <= StDrain;
                                drain_cnt <= 1'b0;
                            end
                        end
                    end
                end
                StDrain: begin
                    // Two cycles lets the last issued sample clear the pipeline.
                    if (drain_cnt) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_d   <= 1'b0;
            neg_sin_d <= 1'b0;
            neg_cos_d <= 1'b0;
            out_valid <= 1'b0;
            sin_out   <= '0;
            cos_out   <= '0;
        end else begin
            issue_d   <= issue;
            neg_sin_d <= quad_sin[1];
            neg_cos_d <= quad_cos[1];
            out_valid <= issue_d;
            if (issue_d) begin
                sin_out <= neg_sin_d ? (DW'(0) - lut_data1) : lut_data1;
                cos_out <= neg_cos_d ? (DW'(0) - lut_data2) : lut_data2;
            end
        end
    end

endmodule

// File: tb/tb_dds_iq_seq.sv
module tb_dds_iq_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] burst_len;
    logic [31:0] phase_init;
    logic [31:0] fcw;
    logic        fcw_we;
    logic [7:0]  lut_addr1;
    logic [7:0]  lut_addr2;
    logic [15:0] lut_data1;
    logic [15:0] lut_data2;
    logic [15:0] sin_out;
    logic [15:0] cos_out;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:255];
    logic [31:0] phs [0:63];

    int n_cmp;
    int n_err;

    dds_iq_seq #(.PW(32), .ABITS(8), .DW(16), .LW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .phase_init (phase_init),
        .fcw        (fcw),
        .fcw_we     (fcw_we),
        .lut_addr1  (lut_addr1),
        .lut_addr2  (lut_addr2),
        .lut_data1  (lut_data1),
        .lut_data2  (lut_data2),
        .sin_out    (sin_out),
        .cos_out    (cos_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered two-port quarter-sine table.
    always @(posedge clk) begin
        lut_data1 <= rom[lut_addr1];
        lut_data2 <= rom[lut_addr2];
    end

    // Reference: a full sine wave built from the quarter table. Quadrants 1 and 3
    // run the quarter backwards, the second half-circle is the negative of the first.
    function automatic logic [15:0] ref_sin(input logic [31:0] p);
        int unsigned q;
        int unsigned k;
        logic [15:0] mag;
        q   = p >> 30;
        k   = (p >> 22) & 255;
        mag = (q % 2 == 1) ? rom[255 - k] : rom[k];
        return (q >= 2) ? (~mag + 16'd1) : mag;
    endfunction

    // cos(p) = sin(p + 90 degrees)
    function automatic logic [15:0] ref_cos(input logic [31:0] p);
        return ref_sin(p + 32'h4000_0000);
    endfunction

    function automatic logic [7:0] ref_addr(input logic [31:0] p);
        int unsigned q;
        int unsigned k;
        q = p >> 30;
        k = (p >> 22) & 255;
        return 8'((q % 2 == 1) ? 255 - k : k);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; optionally loads fcw on the same edge.
    task automatic do_start(input logic [31:0] pi, input logic [15:0] bl,
                            input logic [31:0] f, input logic we);
        start      = 1'b1;
        phase_init = pi;
        burst_len  = bl;
        fcw        = f;
        fcw_we     = we;
        tick();
        start      = 1'b0;
        fcw_we     = 1'b0;
        phase_init = $urandom;
        burst_len  = 16'($urandom);
        fcw        = $urandom;
    endtask

    task automatic test_reset;
        logic [31:0] pi;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, busy, done, sin_out, cos_out} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_init: got v=%0b b=%0b d=%0b s=%0h c=%0h required all 0",
                     out_valid, busy, done, sin_out, cos_out);
        end
        n_cmp++;
        if (lut_addr1 !== 8'd0 || lut_addr2 !== ref_addr(32'h4000_0000)) begin
            n_err++;
            $display("FAIL reset_addr: got %0d/%0d required 0/%0d", lut_addr1, lut_addr2,
                     ref_addr(32'h4000_0000));
        end
        rst = 1'b0;
        tick();

        // Mid-run reset.
        do_start($urandom, 16'd0, $urandom, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({out_valid, busy, done, sin_out, cos_out} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_midrun: got v=%0b b=%0b d=%0b s=%0h c=%0h required all 0",
                     out_valid, busy, done, sin_out, cos_out);
        end
        n_cmp++;
        if (lut_addr1 !== 8'd0 || lut_addr2 !== 8'd255) begin
            n_err++;
            $display("FAIL reset_midrun_addr: got %0d/%0d required 0/255", lut_addr1, lut_addr2);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_after c%0d: got d=%0b b=%0b v=%0b required 0/0/0",
                         c, done, busy, out_valid);
            end
        end

        // fcw_reg cleared by reset: without a load every sample repeats the start phase.
        pi = $urandom;
        do_start(pi, 16'd3, $urandom, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 3) begin
                n_cmp++;
                if (lut_addr1 !== ref_addr(pi)) begin
                    n_err++;
                    $display("FAIL fcw_reset c%0d addr1: got %0d required %0d",
                             c, lut_addr1, ref_addr(pi));
                end
            end
            if (c >= 3) begin
                n_cmp++;
                if (out_valid !== 1'b1 || sin_out !== ref_sin(pi) || cos_out !== ref_cos(pi)) begin
                    n_err++;
                    $display("FAIL fcw_reset c%0d: got v=%0b %0h/%0h required 1 %0h/%0h", c,
                             out_valid, sin_out, cos_out, ref_sin(pi), ref_cos(pi));
                end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_bursts;
        logic [31:0] pis [6];
        int          bls [6];
        logic [31:0] fs  [6];
        int          bl;
        pis[0] = 32'h0000_0000; bls[0] = 4; fs[0] = 32'h0040_0000;
        pis[1] = 32'hC040_0000; bls[1] = 1; fs[1] = 32'h0040_0000;
        pis[2] = 32'hFFC0_0000; bls[2] = 2; fs[2] = 32'h0040_0000;
        for (int s = 3; s < 6; s++) begin
            pis[s] = $urandom;
            bls[s] = $urandom_range(1, 12);
            fs[s]  = $urandom;
        end
        for (int s = 0; s < 6; s++) begin
            bl = bls[s];
            for (int k = 0; k <= bl; k++) phs[k] = pis[s] + 32'(k) * fs[s];
            do_start(pis[s], 16'(bl), fs[s], 1'b1);
            for (int c = 1; c <= bl + 5; c++) begin
                if (c <= bl) begin
                    n_cmp++;
                    if (lut_addr1 !== ref_addr(phs[c-1]) ||
                        lut_addr2 !== ref_addr(phs[c-1] + 32'h4000_0000)) begin
                        n_err++;
                        $display("FAIL burst%0d c%0d addr: got %0d/%0d required %0d/%0d", s, c,
                                 lut_addr1, lut_addr2, ref_addr(phs[c-1]),
                                 ref_addr(phs[c-1] + 32'h4000_0000));
                    end
                end else begin
                    n_cmp++;
                    if (lut_addr1 !== ref_addr(phs[bl])) begin
                        n_err++;
                        $display("FAIL burst%0d c%0d parked addr1: got %0d required %0d",
                                 s, c, lut_addr1, ref_addr(phs[bl]));
                    end
                end
                n_cmp++;
                if (out_valid !== (c >= 3 && c <= bl + 2)) begin
                    n_err++;
                    $display("FAIL burst%0d c%0d valid: got %0b required %0b", s, c,
                             out_valid, (c >= 3 && c <= bl + 2));
                end
                if (c >= 3) begin
                    // Valid samples, then the last one must hold.
                    n_cmp++;
                    if (sin_out !== ref_sin(phs[(c <= bl + 2) ? c - 3 : bl - 1]) ||
                        cos_out !== ref_cos(phs[(c <= bl + 2) ? c - 3 : bl - 1])) begin
                        n_err++;
                        $display("FAIL burst%0d c%0d sample: got %0h/%0h required %0h/%0h", s, c,
                                 sin_out, cos_out,
                                 ref_sin(phs[(c <= bl + 2) ? c - 3 : bl - 1]),
                                 ref_cos(phs[(c <= bl + 2) ? c - 3 : bl - 1]));
                    end
                end
                n_cmp++;
                if (busy !== (c <= bl + 2) || done !== (c == bl + 3)) begin
                    n_err++;
                    $display("FAIL burst%0d c%0d busy/done: got %0b/%0b required %0b/%0b", s, c,
                             busy, done, (c <= bl + 2), (c == bl + 3));
                end
                tick();
            end
        end
    endtask

    task automatic test_stop;
        int          bls [3];
        int          ss  [3];
        int          n_iss;
        int          n_valid;
        logic [31:0] pi;
        logic [31:0] f;
        bls[0] = 0; ss[0] = 11;
        bls[1] = 3; ss[1] = 3;
        bls[2] = 6; ss[2] = 2;
        // Stop in IDLE must do nothing.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pi      = $urandom;
            f       = $urandom;
            n_iss   = ss[s] - 1;
            n_valid = 0;
            for (int k = 0; k <= n_iss; k++) phs[k] = pi + 32'(k) * f;
            do_start(pi, 16'(bls[s]), f, 1'b1);
            for (int c = 1; c <= ss[s] + 4; c++) begin
                n_cmp++;
                if (lut_addr1 !== ref_addr(phs[(c <= n_iss) ? c - 1 : n_iss])) begin
                    n_err++;
                    $display("FAIL stop%0d c%0d addr1: got %0d required %0d", s, c, lut_addr1,
                             ref_addr(phs[(c <= n_iss) ? c - 1 : n_iss]));
                end
                if (out_valid === 1'b1) begin
                    n_valid++;
                    n_cmp++;
                    if (sin_out !== ref_sin(phs[c-3]) || cos_out !== ref_cos(phs[c-3])) begin
                        n_err++;
                        $display("FAIL stop%0d c%0d sample: got %0h/%0h required %0h/%0h", s, c,
                                 sin_out, cos_out, ref_sin(phs[c-3]), ref_cos(phs[c-3]));
                    end
                end
                n_cmp++;
                if (busy !== (c <= ss[s] + 2) || done !== (c == ss[s] + 3)) begin
                    n_err++;
                    $display("FAIL stop%0d c%0d busy/done: got %0b/%0b required %0b/%0b", s, c,
                             busy, done, (c <= ss[s] + 2), (c == ss[s] + 3));
                end
                stop = (c == ss[s]);
                tick();
                stop = 1'b0;
            end
            n_cmp++;
            if (n_valid != n_iss) begin
                n_err++;
                $display("FAIL stop%0d valid_count: got %0d required %0d", s, n_valid, n_iss);
            end
        end
    endtask

    task automatic test_live_fcw_and_ignored;
        logic [31:0] pi;
        logic [31:0] f0;
        logic [31:0] f1;
        int          bl;
        pi = $urandom;
        f0 = $urandom;
        f1 = $urandom;
        bl = 8;
        // Accumulation at the end of issue k uses f0 up to the edge that loads f1.
        phs[0] = pi;
        for (int k = 1; k <= bl; k++) phs[k] = phs[k-1] + ((k <= 3) ? f0 : f1);
        do_start(pi, 16'(bl), f0, 1'b1);
        for (int c = 1; c <= bl + 5; c++) begin
            n_cmp++;
            if (lut_addr1 !== ref_addr(phs[(c <= bl) ? c - 1 : bl])) begin
                n_err++;
                $display("FAIL live c%0d addr1: got %0d required %0d", c, lut_addr1,
                         ref_addr(phs[(c <= bl) ? c - 1 : bl]));
            end
            n_cmp++;
            if (out_valid !== (c >= 3 && c <= bl + 2)) begin
                n_err++;
                $display("FAIL live c%0d valid: got %0b required %0b", c, out_valid,
                         (c >= 3 && c <= bl + 2));
            end
            if (c >= 3 && c <= bl + 2) begin
                n_cmp++;
                if (sin_out !== ref_sin(phs[c-3]) || cos_out !== ref_cos(phs[c-3])) begin
                    n_err++;
                    $display("FAIL live c%0d sample: got %0h/%0h required %0h/%0h", c,
                             sin_out, cos_out, ref_sin(phs[c-3]), ref_cos(phs[c-3]));
                end
            end
            n_cmp++;
            if (busy !== (c <= bl + 2) || done !== (c == bl + 3)) begin
                n_err++;
                $display("FAIL live c%0d busy/done: got %0b/%0b required %0b/%0b", c,
                         busy, done, (c <= bl + 2), (c == bl + 3));
            end
            fcw        = f1;
            fcw_we     = (c == 3);
            start      = (c == 5) || (c == bl + 2);
            phase_init = ~pi;
            burst_len  = 16'd1;
            stop       = (c == bl + 1);
            tick();
            fcw_we = 1'b0;
            start  = 1'b0;
            stop   = 1'b0;
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        burst_len  = '0;
        phase_init = '0;
        fcw        = '0;
        fcw_we     = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(0, 32767));
        test_reset();
        test_bursts();
        test_stop();
        test_live_fcw_and_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
